// File: rtl/hlsm_mul_array.sv
// Multi-lane signed multiply / multiply-accumulate engine with a Start/Done handshake.
// Operands are latched on Start; saturated results are written as the compute state is left.
module hlsm_mul_array #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int LATENCY  = 2,
   parameter int MODE     = 0
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_start,
   input  logic                      i_clr,
   input  logic [CHANNELS*WIDTH-1:0] i_a,
   input  logic [CHANNELS*WIDTH-1:0] i_b,
   output logic                      o_done,
   output logic                      o_busy,
   output logic [CHANNELS*WIDTH-1:0] o_y,
   output logic [CHANNELS-1:0]       o_ovf
);

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] LP_CNT_INIT = CW'(LATENCY - 1);
   localparam logic [CW-1:0] LP_CNT_ONE  = CW'(1);

   localparam logic [1:0] S_WAIT  = 2'd0;
   localparam logic [1:0] S_CALC  = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;

   // Saturation bounds expressed in the widened (2*WIDTH+1) sum domain.
   localparam logic signed [2*WIDTH:0] LP_MAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [2*WIDTH:0] LP_MIN = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] LP_YMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] LP_YMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]                r_state;
   logic [CW-1:0]             r_cnt;
   logic [CHANNELS*WIDTH-1:0] r_a;
   logic [CHANNELS*WIDTH-1:0] r_b;
   logic [CHANNELS*WIDTH-1:0] r_y;
   logic [CHANNELS-1:0]       r_ovf;
   logic                      r_done;
   logic                      r_busy;

   logic [CHANNELS*WIDTH-1:0] w_y_next;
   logic [CHANNELS-1:0]       w_sat;

   always_comb begin
      logic signed [2*WIDTH-1:0] v_a;
      logic signed [2*WIDTH-1:0] v_b;
      logic signed [2*WIDTH-1:0] v_p;
      logic signed [2*WIDTH:0]   v_s;
      w_y_next = '0;
      w_sat    = '0;
      v_a      = '0;
      v_b      = '0;
      v_p      = '0;
      v_s      = '0;
      for (int unsigned n = 0; n < CHANNELS; n++) begin
         v_a = {{WIDTH{r_a[n*WIDTH+WIDTH-1]}}, r_a[n*WIDTH +: WIDTH]};
         v_b = {{WIDTH{r_b[n*WIDTH+WIDTH-1]}}, r_b[n*WIDTH +: WIDTH]};
         v_p = v_a * v_b;
         v_s = {v_p[2*WIDTH-1], v_p};
         if (MODE != 0) begin
            v_s = v_s + {{(WIDTH+1){r_y[n*WIDTH+WIDTH-1]}}, r_y[n*WIDTH +: WIDTH]};
         end
         if (v_s > LP_MAX) begin
            w_y_next[n*WIDTH +: WIDTH] = LP_YMAX;
            w_sat[n]                   = 1'b1;
         end else if (v_s < LP_MIN) begin
            w_y_next[n*WIDTH +: WIDTH] = LP_YMIN;
            w_sat[n]                   = 1'b1;
         end else begin
            w_y_next[n*WIDTH +: WIDTH] = v_s[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_WAIT;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_y     <= '0;
         r_ovf   <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_WAIT: begin
               r_done <= 1'b0;
               // Clear lands before the accumulate reads r_y, so Clr+Start accumulates from 0.
               if (i_clr) begin
                  r_y   <= '0;
                  r_ovf <= '0;
               end
               if (i_start) begin
                  r_a     <= i_a;
                  r_b     <= i_b;
                  r_cnt   <= LP_CNT_INIT;
                  r_busy  <= 1'b1;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               if (r_cnt == '0) begin
                  r_y     <= w_y_next;
                  r_ovf   <= r_ovf | w_sat;
                  r_state <= S_FINAL;
               end else begin
                  r_cnt <= r_cnt - LP_CNT_ONE;
               end
            end
            S_FINAL: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_WAIT;
            end
            default: r_state <= S_WAIT;
         endcase
      end
   end

   assign o_done = r_done;
   assign o_busy = r_busy;
   assign o_y    = r_y;
   assign o_ovf  = r_ovf;

endmodule
